// File: rtl/wb_dpbram_arbiter_if.sv
// wb_dpbram_arbiter_if: two Wishbone B4 pipelined masters plus one BRAM port, bundled for the arbiter.
interface wb_dpbram_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  logic                  i_cyc0, i_cyc1;
  logic                  i_stb0, i_stb1;
  logic                  i_we0, i_we1;
  logic [ADDR_WIDTH-1:0] i_addr0, i_addr1;
  logic [DATA_WIDTH-1:0] i_data0, i_data1;
  logic                  o_stall0, o_stall1;
  logic                  o_ack0, o_ack1;
  logic [DATA_WIDTH-1:0] o_data0, o_data1;
  logic                  o_bram_en;
  logic                  o_bram_we;
  logic [ADDR_WIDTH-1:0] o_bram_addr;
  logic [DATA_WIDTH-1:0] o_bram_din;
  logic [DATA_WIDTH-1:0] i_bram_dout;
  modport slave (
    input  i_cyc0, i_cyc1, i_stb0, i_stb1, i_we0, i_we1,
    input  i_addr0, i_addr1, i_data0, i_data1, i_bram_dout,
    output o_stall0, o_stall1, o_ack0, o_ack1, o_data0, o_data1,
    output o_bram_en, o_bram_we, o_bram_addr, o_bram_din
  );
  modport master (
    output i_cyc0, i_cyc1, i_stb0, i_stb1, i_we0, i_we1,
    output i_addr0, i_addr1, i_data0, i_data1, i_bram_dout,
    input  o_stall0, o_stall1, o_ack0, o_ack1, o_data0, o_data1,
    input  o_bram_en, o_bram_we, o_bram_addr, o_bram_din
  );
endinterface

// File: rtl/wb_dpbram_arbiter.sv
// wb_dpbram_arbiter: round-robin two-master Wishbone arbiter for one BRAM port.
// Define WBDPBRAM_ARB_TIMEOUT_EN to preempt a master after HOLD_MAX granted cycles when the other waits.
module wb_dpbram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int HOLD_MAX   = 16
) (
  input logic                 i_clk,
  input logic                 i_reset_n,
  wb_dpbram_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t     state, state_nx;
  logic       last;
  logic [1:0] ack_q;
  logic       gnt0, gnt1, acc0, acc1, preempt;
  assign gnt0 = state == GNT0;
  assign gnt1 = state == GNT1;
  assign acc0 = gnt0 & bus.i_stb0;
  assign acc1 = gnt1 & bus.i_stb1;
`ifdef WBDPBRAM_ARB_TIMEOUT_EN
  localparam int HW = $clog2(HOLD_MAX) + 1;
  logic [HW-1:0] hold;
  assign preempt = (hold == HW'(HOLD_MAX - 1)) & (gnt0 ? bus.i_cyc1 : bus.i_cyc0);
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) hold <= '0;
    else hold <= (state_nx != state || state == IDLE) ? '0 : hold + HW'(1);
`else
  logic unused_hold;
  assign unused_hold = ^HOLD_MAX;
  assign preempt = 1'b0;
`endif
  always_comb begin
    state_nx = IDLE;
    unique case (state)
      IDLE:    state_nx = (bus.i_cyc0 & bus.i_cyc1) ? (last ? GNT0 : GNT1) :
                          bus.i_cyc0 ? GNT0 : bus.i_cyc1 ? GNT1 : IDLE;
      GNT0:    state_nx = (bus.i_cyc0 & !preempt) ? GNT0 : bus.i_cyc1 ? GNT1 : IDLE;
      GNT1:    state_nx = (bus.i_cyc1 & !preempt) ? GNT1 : bus.i_cyc0 ? GNT0 : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // ack_q bit n doubles as the routing tag: the ack returns to whoever issued it, not to the current owner
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state <= IDLE;
      last  <= 1'b1;
      ack_q <= '0;
    end else begin
      state <= state_nx;
      last  <= (state_nx == GNT0) ? 1'b0 : (state_nx == GNT1) ? 1'b1 : last;
      ack_q <= {acc1, acc0};
    end
  assign bus.o_stall0    = !gnt0;
  assign bus.o_stall1    = !gnt1;
  assign bus.o_bram_en   = acc0 | acc1;
  assign bus.o_bram_we   = gnt0 ? bus.i_we0 : gnt1 & bus.i_we1;
  assign bus.o_bram_addr = gnt0 ? bus.i_addr0 : gnt1 ? bus.i_addr1 : '0;
  assign bus.o_bram_din  = gnt0 ? bus.i_data0 : gnt1 ? bus.i_data1 : '0;
  assign bus.o_ack0      = ack_q[0] & bus.i_cyc0;
  assign bus.o_ack1      = ack_q[1] & bus.i_cyc1;
  assign bus.o_data0     = bus.o_ack0 ? bus.i_bram_dout : '0;
  assign bus.o_data1     = bus.o_ack1 ? bus.i_bram_dout : '0;
endmodule

// File: tb/tb_wb_dpbram_arbiter.sv
// tb_wb_dpbram_arbiter: vector table plus corner-case sequences with a per-master read-data scoreboard.
module tb_wb_dpbram_arbiter;
  localparam int DW = 8, AW = 10, HOLD = 4, NSTREAM = 12;
  typedef struct {
    int          m;
    logic        we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] exp;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, load = 1'b1;
  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] q0[$], q1[$];
  logic [DW-1:0] mem [0:(1<<AW)-1];
  vec_t tbl [10];
  wb_dpbram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
  wb_dpbram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .HOLD_MAX(HOLD)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  // BRAM port model: registered read, read-before-write
  always @(posedge clk)
    if (load) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= (i < 4) ? DW'(16 + i) : '0;
    end else if (bus.o_bram_en) begin
      bus.i_bram_dout <= mem[bus.o_bram_addr];
      if (bus.o_bram_we) mem[bus.o_bram_addr] <= bus.o_bram_din;
    end
  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction
  function automatic void spurious(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got an ack, required none", name);
  endfunction
  always @(negedge clk) begin
    if (bus.o_ack0) begin
      if (q0.size() == 0) spurious("ack0");
      else check("data0", 32'(bus.o_data0), 32'(q0.pop_front()));
    end
    if (bus.o_ack1) begin
      if (q1.size() == 0) spurious("ack1");
      else check("data1", 32'(bus.o_data1), 32'(q1.pop_front()));
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int m, input logic c, input logic s, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (m == 0) begin
      bus.i_cyc0 = c; bus.i_stb0 = s; bus.i_we0 = w; bus.i_addr0 = a; bus.i_data0 = d;
    end else begin
      bus.i_cyc1 = c; bus.i_stb1 = s; bus.i_we1 = w; bus.i_addr1 = a; bus.i_data1 = d;
    end
  endtask
  function automatic void push(input int m, input logic [DW-1:0] d);
    if (m == 0) q0.push_back(d);
    else q1.push_back(d);
  endfunction
  function automatic logic stall_of(input int m);
    return (m != 0) ? bus.o_stall1 : bus.o_stall0;
  endfunction
  function automatic logic ack_of(input int m);
    return (m != 0) ? bus.o_ack1 : bus.o_ack0;
  endfunction
  function automatic int owner(input int k);
`ifdef WBDPBRAM_ARB_TIMEOUT_EN
    return (k / HOLD) % 2;
`else
    return (k < 0) ? 1 : 0;
`endif
  endfunction
  task automatic single(input vec_t v);
    logic got = 1'b0;
    int waits = 99;
    drive(v.m, 1'b1, 1'b1, v.we, v.addr, v.din);
    for (int w = 0; w < 8 && !got; w++) begin
      @(negedge clk);
      if (!stall_of(v.m)) begin
        got = 1'b1;
        waits = w;
      end else tick();
    end
    check("grant_latency", 32'(waits), 1);
    if (got) begin
      push(v.m, v.exp);
      tick();
      drive(v.m, 1'b1, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      check("ack_latency", 32'(ack_of(v.m)), 1);
    end
    tick();
    drive(v.m, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    tbl[0] = '{0, 1'b1, 10'h003, 8'hA5, 8'h13};
    tbl[1] = '{0, 1'b0, 10'h003, 8'h00, 8'hA5};
    tbl[2] = '{1, 1'b1, 10'h005, 8'h3C, 8'h00};
    tbl[3] = '{1, 1'b0, 10'h005, 8'h00, 8'h3C};
    tbl[4] = '{0, 1'b0, 10'h002, 8'h00, 8'h12};
    tbl[5] = '{1, 1'b1, 10'h002, 8'h77, 8'h12};
    tbl[6] = '{0, 1'b0, 10'h002, 8'h00, 8'h77};
    tbl[7] = '{1, 1'b0, 10'h3FF, 8'h00, 8'h00};
    tbl[8] = '{0, 1'b1, 10'h3FF, 8'hFF, 8'h00};
    tbl[9] = '{1, 1'b0, 10'h3FF, 8'h00, 8'hFF};
    drive(0, 1'b1, 1'b1, 1'b1, 10'h155, 8'h5A);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    load = 1'b0;
    check("rst_stall0", 32'(bus.o_stall0), 1);
    check("rst_stall1", 32'(bus.o_stall1), 1);
    check("rst_ack0", 32'(bus.o_ack0), 0);
    check("rst_ack1", 32'(bus.o_ack1), 0);
    check("rst_en", 32'(bus.o_bram_en), 0);
    check("rst_we", 32'(bus.o_bram_we), 0);
    check("rst_addr", 32'(bus.o_bram_addr), 0);
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    // simultaneous requests: master 0 first, then alternate, handover without IDLE
    drive(0, 1'b1, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b1, 1'b0, 1'b0, '0, '0);
    tick();
    @(negedge clk);
    check("tie_a_stall0", 32'(bus.o_stall0), 0);
    check("tie_a_stall1", 32'(bus.o_stall1), 1);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    drive(0, 1'b1, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b1, 1'b0, 1'b0, '0, '0);
    tick();
    @(negedge clk);
    check("tie_b_stall1", 32'(bus.o_stall1), 0);
    check("tie_b_stall0", 32'(bus.o_stall0), 1);
    tick();
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    @(negedge clk);
    check("handover_stall0", 32'(bus.o_stall0), 0);
    check("handover_stall1", 32'(bus.o_stall1), 1);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    // four-read burst from master 0
    drive(0, 1'b1, 1'b1, 1'b0, 10'h000, '0);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("burst_stall0", 32'(bus.o_stall0), 0);
      if (i > 0) check("burst_ack0", 32'(bus.o_ack0), 1);
      push(0, DW'(16 + i));
      tick();
      if (i < 3) bus.i_addr0 = AW'(i + 1);
      else bus.i_stb0 = 1'b0;
    end
    @(negedge clk);
    check("burst_last_ack0", 32'(bus.o_ack0), 1);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    for (int i = 0; i < 10; i++) single(tbl[i]);
    // master 0 abandons its cycle while its ack is due
    drive(0, 1'b1, 1'b1, 1'b0, 10'h010, '0);
    tick();
    @(negedge clk);
    check("drop_stall0", 32'(bus.o_stall0), 0);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b1, 1'b1, 1'b0, 10'h001, '0);
    @(negedge clk);
    check("drop_ack0", 32'(bus.o_ack0), 0);
    check("drop_data0", 32'(bus.o_data0), 0);
    tick();
    @(negedge clk);
    check("drop_stall1", 32'(bus.o_stall1), 0);
    push(1, 8'h11);
    tick();
    drive(1, 1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("drop_ack1", 32'(bus.o_ack1), 1);
    tick();
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    // asynchronous reset with an ack outstanding
    drive(0, 1'b1, 1'b1, 1'b0, 10'h000, '0);
    tick();
    @(negedge clk);
    push(0, 8'h10);
    tick();
    check("pre_rst_ack0", 32'(bus.o_ack0), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack0", 32'(bus.o_ack0), 0);
    check("mid_rst_stall0", 32'(bus.o_stall0), 1);
    check("mid_rst_stall1", 32'(bus.o_stall1), 1);
    check("mid_rst_en", 32'(bus.o_bram_en), 0);
    q0.delete();
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    // both masters streaming reads
    drive(0, 1'b1, 1'b1, 1'b0, 10'h000, '0);
    drive(1, 1'b1, 1'b1, 1'b0, 10'h001, '0);
    tick();
    for (int k = 0; k < NSTREAM; k++) begin
      @(negedge clk);
      check("stream_stall0", 32'(bus.o_stall0), (owner(k) != 0) ? 1 : 0);
      check("stream_stall1", 32'(bus.o_stall1), (owner(k) != 1) ? 1 : 0);
      check("stream_ack0", 32'(bus.o_ack0), (k > 0 && owner(k-1) == 0) ? 1 : 0);
      check("stream_ack1", 32'(bus.o_ack1), (k > 0 && owner(k-1) == 1) ? 1 : 0);
      push(owner(k), (owner(k) != 0) ? 8'h11 : 8'h10);
      tick();
    end
    bus.i_stb0 = 1'b0;
    bus.i_stb1 = 1'b0;
    @(negedge clk);
    check("stream_last_ack", 32'(ack_of(owner(NSTREAM-1))), 1);
`ifndef WBDPBRAM_ARB_TIMEOUT_EN
    tick();
    bus.i_cyc0 = 1'b0;
    tick();
    @(negedge clk);
    check("release_stall1", 32'(bus.o_stall1), 0);
`endif
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    check("q0_leftover", 32'(q0.size()), 0);
    check("q1_leftover", 32'(q1.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
